// File: rtl/rocc_cmd_queue.sv
// rocc_cmd_queue: in-order RoCC command FIFO issuing one command at a time
// to an accelerator, tagging results with rd and measuring issue latency.
module rocc_cmd_queue #(
  parameter int QUEUE_DEPTH = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int RD_WIDTH    = 5,
  parameter int LAT_WIDTH   = 32,
  localparam int PTR_W = $clog2(QUEUE_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_cmd_valid,
  output logic                  cpu_cmd_ready,
  input  logic [6:0]            cpu_cmd_opcode,
  input  logic [RD_WIDTH-1:0]   cpu_cmd_rd,
  input  logic [DATA_WIDTH-1:0] cpu_cmd_rs1,
  input  logic [DATA_WIDTH-1:0] cpu_cmd_rs2,
  output logic                  acc_cmd_valid,
  input  logic                  acc_cmd_ready,
  output logic [6:0]            acc_cmd_opcode,
  output logic [DATA_WIDTH-1:0] acc_cmd_rs1,
  output logic [DATA_WIDTH-1:0] acc_cmd_rs2,
  input  logic                  acc_resp_valid,
  output logic                  acc_resp_ready,
  input  logic [DATA_WIDTH-1:0] acc_resp_data,
  output logic                  cpu_resp_valid,
  input  logic                  cpu_resp_ready,
  output logic [RD_WIDTH-1:0]   cpu_resp_rd,
  output logic [DATA_WIDTH-1:0] cpu_resp_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      occupancy,
  output logic [LAT_WIDTH-1:0]  last_latency
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [6:0]            r_op  [QUEUE_DEPTH];
  logic [RD_WIDTH-1:0]   r_rd  [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] r_rs1 [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] r_rs2 [QUEUE_DEPTH];

  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [RD_WIDTH-1:0]   r_rd_hold;
  logic [LAT_WIDTH-1:0]  r_lat;
  logic [LAT_WIDTH-1:0]  r_last_lat;
  logic [RD_WIDTH-1:0]   r_resp_rd;
  logic [DATA_WIDTH-1:0] r_resp_data;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_resp_hs;
  logic [LAT_WIDTH-1:0]  w_lat_inc;

  // ready is forced low while reset is held, then follows fullness only
  assign cpu_cmd_ready = reset && (r_count != CNT_W'(QUEUE_DEPTH));
  assign w_push    = cpu_cmd_valid && cpu_cmd_ready;
  assign w_pop     = (r_state == S_ISSUE) && acc_cmd_ready;
  assign w_resp_hs = (r_state == S_WAIT) && acc_resp_valid;
  assign w_lat_inc = (&r_lat) ? r_lat : r_lat + LAT_WIDTH'(1);

  assign acc_cmd_opcode = r_op[r_rptr];
  assign acc_cmd_rs1    = r_rs1[r_rptr];
  assign acc_cmd_rs2    = r_rs2[r_rptr];
  assign cpu_resp_rd    = r_resp_rd;
  assign cpu_resp_data  = r_resp_data;
  assign occupancy      = r_count;
  assign last_latency   = r_last_lat;
  assign busy           = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_op[r_wptr]  <= cpu_cmd_opcode;
      r_rd[r_wptr]  <= cpu_cmd_rd;
      r_rs1[r_wptr] <= cpu_cmd_rs1;
      r_rs2[r_wptr] <= cpu_cmd_rs2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (r_count != '0)  w_state_nxt = S_ISSUE;
      S_ISSUE: if (acc_cmd_ready)  w_state_nxt = S_WAIT;
      S_WAIT:  if (acc_resp_valid) w_state_nxt = S_RESP;
      S_RESP:  if (cpu_resp_ready) w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    acc_cmd_valid  = 1'b0;
    acc_resp_ready = 1'b0;
    cpu_resp_valid = 1'b0;
    unique case (r_state)
      S_ISSUE: acc_cmd_valid  = 1'b1;
      S_WAIT:  acc_resp_ready = 1'b1;
      S_RESP:  cpu_resp_valid = 1'b1;
      default: ;
    endcase
  end

  // counter holds edges since issue; the response edge itself adds one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_hold   <= '0;
      r_lat       <= '0;
      r_last_lat  <= '0;
      r_resp_rd   <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_pop) begin
        r_rd_hold <= r_rd[r_rptr];
        r_lat     <= '0;
      end else if (r_state == S_WAIT) begin
        r_lat <= w_lat_inc;
      end
      if (w_resp_hs) begin
        r_resp_data <= acc_resp_data;
        r_resp_rd   <= r_rd_hold;
        r_last_lat  <= w_lat_inc;
      end
    end
  end

endmodule
